// File: rtl/ycbcr_pkg.sv
// ---------------------------------------------------------------------------
// ycbcr_pkg
// Shared constants and arithmetic helpers for the BT.601 RGB->YCbCr pipeline.
//   - K_*   : conversion coefficients scaled by 256
//   - Y_OFF/C_OFF : luma / chroma output offsets (also the blanking level)
//   - Y_MIN/Y_MAX/C_MAX : studio-range clamp limits (chroma low limit = Y_MIN)
//   - LAT   : input-to-output latency in pclk cycles
// Build option: YCBCR_422_EN selects 4:2:2 output (LAT=4); undefined gives
// 4:4:4 output (LAT=3).
// ---------------------------------------------------------------------------
package ycbcr_pkg;

  localparam logic signed [9:0] K_YR  =  10'sd66;
  localparam logic signed [9:0] K_YG  =  10'sd129;
  localparam logic signed [9:0] K_YB  =  10'sd25;
  localparam logic signed [9:0] K_CBR = -10'sd38;
  localparam logic signed [9:0] K_CBG = -10'sd74;
  localparam logic signed [9:0] K_CBB =  10'sd112;
  localparam logic signed [9:0] K_CRR =  10'sd112;
  localparam logic signed [9:0] K_CRG = -10'sd94;
  localparam logic signed [9:0] K_CRB = -10'sd18;

  localparam logic signed [17:0] RND = 18'sd128;

  localparam logic [7:0] Y_OFF = 8'd16;
  localparam logic [7:0] C_OFF = 8'd128;
  localparam logic [7:0] Y_MIN = 8'd16;
  localparam logic [7:0] Y_MAX = 8'd235;
  localparam logic [7:0] C_MAX = 8'd240;

`ifdef YCBCR_422_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  // Component zero-extended to signed 10 bit, product kept as signed 18 bit.
  function automatic logic signed [17:0] mul_k(input logic [7:0] c,
                                                input logic signed [9:0] k);
    logic signed [9:0]  a;
    logic signed [19:0] p;
    a = signed'({2'b00, c});
    p = 20'(a) * 20'(k);
    return p[17:0];
  endfunction

  // Floor-shift the rounded sum, add the offset and clamp to [lo, hi].
  function automatic logic [7:0] scale_clamp(input logic signed [17:0] s,
                                             input logic [7:0] off,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
    int v;
    v = int'(s) >>> 8;
    v = v + int'(off);
    if (v < int'(lo))      v = int'(lo);
    else if (v > int'(hi)) v = int'(hi);
    return 8'(v);
  endfunction

  // Rounded average of two components, (a + b + 1) >> 1.
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(t >> 1);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// ---------------------------------------------------------------------------
// sync_delay
// N-stage register delay line of width W, asynchronously cleared to 0.
// Used to keep DE/HSYNC/VSYNC aligned with the arithmetic pipeline.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : input word
//   o_q     : i_d delayed N cycles
// ---------------------------------------------------------------------------
module sync_delay #(
  parameter int N = 3,
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [N];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[N-1];

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// ---------------------------------------------------------------------------
// rgb2ycbcr_pipe
// Pipelined BT.601 RGB -> studio-range YCbCr converter on the pixel clock.
// Stage 1 registers the nine products, stage 2 the three rounded sums,
// stage 3 shifts/offsets/clamps into the output registers. Syncs and DE are
// delay-matched; outputs read black (16,128,128) whenever de_out is low.
// Build option YCBCR_422_EN: an extra stage decimates chroma to 4:2:2 on
// cb_out (Cb on even phase, Cr on odd phase, pairwise averaged), cr_out is
// held at 128, and latency becomes 4.
// Ports:
//   pclk, rstbtn_n                 : pixel clock, async active-low reset
//   de_in, hsync_in, vsync_in      : timing in
//   red_in, green_in, blue_in      : 8-bit RGB in
//   de_out, hsync_out, vsync_out   : timing delayed LAT cycles
//   y_out, cb_out, cr_out          : YCbCr out
// ---------------------------------------------------------------------------
module rgb2ycbcr_pipe
  import ycbcr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          pclk,
  input  logic          rstbtn_n,
  input  logic          de_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [DW-1:0] red_in,
  input  logic [DW-1:0] green_in,
  input  logic [DW-1:0] blue_in,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] cb_out,
  output logic [DW-1:0] cr_out
);

  localparam int LAT = ycbcr_pkg::LAT;

  logic signed [17:0] r_prod [9];
  logic signed [17:0] r_sum_y, r_sum_cb, r_sum_cr;
  logic [7:0]         r_y, r_cb, r_cr;
  logic [2:0]         w_sync2, w_sync_out;
  logic               w_de2;
  logic [7:0]         w_y, w_cb, w_cr;

  // Timing tap aligned with the stage-2 sums, then the remaining delay.
  sync_delay #(.N(2), .W(3)) u_sync_pre (
    .i_clk   (pclk),
    .i_rst_n (rstbtn_n),
    .i_d     ({de_in, hsync_in, vsync_in}),
    .o_q     (w_sync2)
  );

  sync_delay #(.N(LAT-2), .W(3)) u_sync_out (
    .i_clk   (pclk),
    .i_rst_n (rstbtn_n),
    .i_d     (w_sync2),
    .o_q     (w_sync_out)
  );

  assign w_de2     = w_sync2[2];
  assign de_out    = w_sync_out[2];
  assign hsync_out = w_sync_out[1];
  assign vsync_out = w_sync_out[0];

  // Stage 1: products
  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      for (int i = 0; i < 9; i++) r_prod[i] <= '0;
    end else begin
      r_prod[0] <= mul_k(red_in,   K_YR);
      r_prod[1] <= mul_k(green_in, K_YG);
      r_prod[2] <= mul_k(blue_in,  K_YB);
      r_prod[3] <= mul_k(red_in,   K_CBR);
      r_prod[4] <= mul_k(green_in, K_CBG);
      r_prod[5] <= mul_k(blue_in,  K_CBB);
      r_prod[6] <= mul_k(red_in,   K_CRR);
      r_prod[7] <= mul_k(green_in, K_CRG);
      r_prod[8] <= mul_k(blue_in,  K_CRB);
    end
  end

  // Stage 2: sums with the rounding constant folded in
  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      r_sum_y  <= '0;
      r_sum_cb <= '0;
      r_sum_cr <= '0;
    end else begin
      r_sum_y  <= r_prod[0] + r_prod[1] + r_prod[2] + RND;
      r_sum_cb <= r_prod[3] + r_prod[4] + r_prod[5] + RND;
      r_sum_cr <= r_prod[6] + r_prod[7] + r_prod[8] + RND;
    end
  end

  // Stage 3 combinational: shift, offset, clamp
  assign w_y  = scale_clamp(r_sum_y,  Y_OFF, Y_MIN, Y_MAX);
  assign w_cb = scale_clamp(r_sum_cb, C_OFF, Y_MIN, C_MAX);
  assign w_cr = scale_clamp(r_sum_cr, C_OFF, Y_MIN, C_MAX);

`ifdef YCBCR_422_EN
  logic [7:0] r3_y, r3_cb, r3_cr, r_prev_cr;
  logic       r3_de, r3_ph;

  // Even-phase pixels need the next pixel's Cb, which is still in the
  // stage-3 combinational path (w_cb) when the current pixel sits in r3_*.
  // Odd-phase pixels pair with the previous pixel's Cr (r_prev_cr).
  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      r3_y      <= '0;
      r3_cb     <= '0;
      r3_cr     <= '0;
      r3_de     <= 1'b0;
      r3_ph     <= 1'b0;
      r_prev_cr <= '0;
      r_y       <= Y_OFF;
      r_cb      <= C_OFF;
      r_cr      <= C_OFF;
    end else begin
      r3_y      <= w_y;
      r3_cb     <= w_cb;
      r3_cr     <= w_cr;
      r3_de     <= w_de2;
      // phase restarts at 0 on the first pixel after a blank gap
      r3_ph     <= r3_de ? ~r3_ph : 1'b0;
      r_prev_cr <= r3_cr;
      r_cr      <= C_OFF;
      if (!r3_de) begin
        r_y  <= Y_OFF;
        r_cb <= C_OFF;
      end else begin
        r_y <= r3_y;
        if (!r3_ph) r_cb <= avg8(r3_cb, w_de2 ? w_cb : r3_cb);
        else        r_cb <= avg8(r_prev_cr, r3_cr);
      end
    end
  end
`else
  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      r_y  <= Y_OFF;
      r_cb <= C_OFF;
      r_cr <= C_OFF;
    end else if (!w_de2) begin
      r_y  <= Y_OFF;
      r_cb <= C_OFF;
      r_cr <= C_OFF;
    end else begin
      r_y  <= w_y;
      r_cb <= w_cb;
      r_cr <= w_cr;
    end
  end
`endif

  assign y_out  = r_y;
  assign cb_out = r_cb;
  assign cr_out = r_cr;

endmodule
